// File: rtl/tile_pkg.sv
`default_nettype none
// ============================================================================
// Module      : tile_pkg
// Description : Shared types and constants for the tile blitter.
// Revision    : 1.0 - initial release
// ============================================================================
package tile_pkg;

    // Blitter control states
    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        FETCH = 3'd1,
        EMIT  = 3'd2,
        ADV   = 3'd3,
        DONE  = 3'd4
    } state_t;

    // Each pixel is stored as R, G, B bytes in consecutive ROM locations
    localparam int BYTES_PER_PIX = 3;

    // Magenta is the conventional transparent key
    localparam logic [23:0] DEFAULT_KEY_RGB = 24'hFF00FF;

endpackage : tile_pkg
`default_nettype wire

// File: rtl/tile_addr_gen.sv
`default_nettype none
// ============================================================================
// Module      : tile_addr_gen
// Description : Destination col/row raster counters, flip mapping and the
//               3*(srow*TILE_W+scol) byte offset of the pixel to fetch next.
// Revision    : 1.0 - initial release
// ============================================================================
module tile_addr_gen
    import tile_pkg::*;
#(
    parameter int TILE_W = 8,
    parameter int TILE_H = 8,
    parameter int ADDR_W = 12
) (
    input  logic                      clk,
    input  logic                      resetn,
    input  logic                      clear,
    input  logic                      step,
    input  logic                      flip_x,
    input  logic                      flip_y,
    output logic [$clog2(TILE_W)-1:0] col,
    output logic [$clog2(TILE_H)-1:0] row,
    output logic                      last,
    output logic [ADDR_W-1:0]         offset
);

    localparam int                   c_COL_W   = $clog2(TILE_W);
    localparam int                   c_ROW_W   = $clog2(TILE_H);
    localparam logic [c_COL_W-1:0]   c_COL_MAX = c_COL_W'(TILE_W - 1);
    localparam logic [c_ROW_W-1:0]   c_ROW_MAX = c_ROW_W'(TILE_H - 1);

    logic [c_COL_W-1:0]         r_col;
    logic [c_ROW_W-1:0]         r_row;
    logic [c_COL_W-1:0]         w_nxt_col;
    logic [c_ROW_W-1:0]         w_nxt_row;
    logic [c_COL_W-1:0]         w_sel_col;
    logic [c_ROW_W-1:0]         w_sel_row;
    logic [c_COL_W-1:0]         w_scol;
    logic [c_ROW_W-1:0]         w_srow;
    logic [c_COL_W+c_ROW_W-1:0] w_idx;
    logic [ADDR_W-1:0]          w_idx_ext;

    // Raster counters: held at the origin while idle, col runs fastest
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_col <= '0;
            r_row <= '0;
        end else if (clear) begin
            r_col <= '0;
            r_row <= '0;
        end else if (step) begin
            r_col <= w_nxt_col;
            r_row <= w_nxt_row;
        end
    end

    // Offset of the pixel about to be fetched: the origin when idle,
    // otherwise the raster successor of the current position. With
    // power-of-two sizes, W-1-c is ~c and srow*W+scol is a concatenation.
    always_comb begin
        w_nxt_col = r_col + c_COL_W'(1);
        w_nxt_row = (r_col == c_COL_MAX) ? r_row + c_ROW_W'(1) : r_row;
        w_sel_col = clear ? '0 : w_nxt_col;
        w_sel_row = clear ? '0 : w_nxt_row;
        w_scol    = flip_x ? ~w_sel_col : w_sel_col;
        w_srow    = flip_y ? ~w_sel_row : w_sel_row;
        w_idx     = {w_srow, w_scol};
        w_idx_ext = ADDR_W'(w_idx);
        offset    = (w_idx_ext << 1) + w_idx_ext;
    end

    assign col  = r_col;
    assign row  = r_row;
    assign last = (r_col == c_COL_MAX) && (r_row == c_ROW_MAX);

endmodule : tile_addr_gen
`default_nettype wire

// File: rtl/tile_blitter.sv
`default_nettype none
// ============================================================================
// Module      : tile_blitter
// Description : Copies a TILE_W x TILE_H RGB tile from a byte-wide ROM to a
//               valid/ready pixel-write stream, with flips, colour keying
//               and a configurable ROM read latency.
// Revision    : 1.0 - initial release
// ============================================================================
module tile_blitter
    import tile_pkg::*;
#(
    parameter int          TILE_W      = 8,
    parameter int          TILE_H      = 8,
    parameter int          COORD_W     = 8,
    parameter int          ADDR_W      = 12,
    parameter int          ROM_LATENCY = 1,
    parameter logic [23:0] KEY_RGB     = DEFAULT_KEY_RGB
) (
    input  logic               clk,
    input  logic               resetn,
    input  logic               start,
    input  logic [ADDR_W-1:0]  tile_base,
    input  logic [COORD_W-1:0] x_pos,
    input  logic [COORD_W-1:0] y_pos,
    input  logic               flip_x,
    input  logic               flip_y,
    input  logic               key_en,
    output logic [ADDR_W-1:0]  rom_addr,
    input  logic [7:0]         rom_data,
    output logic               pix_valid,
    input  logic               pix_ready,
    output logic [COORD_W-1:0] pix_x,
    output logic [COORD_W-1:0] pix_y,
    output logic [23:0]        pix_rgb,
    output logic               busy,
    output logic               done
);

    localparam int c_COL_W = $clog2(TILE_W);
    localparam int c_ROW_W = $clog2(TILE_H);

    state_t               r_state;
    state_t               w_state_nxt;

    logic [ADDR_W-1:0]    r_base;
    logic [COORD_W-1:0]   r_x;
    logic [COORD_W-1:0]   r_y;
    logic                 r_flip_x;
    logic                 r_flip_y;
    logic                 r_key_en;

    logic [1:0]           r_issue;
    logic [ROM_LATENCY-1:0] r_tag_vld;
    logic [1:0]           r_tag_slot [ROM_LATENCY];
    logic [7:0]           r_red;
    logic [7:0]           r_grn;

    logic                 w_idle;
    logic                 w_start;
    logic                 w_fetch;
    logic                 w_issue;
    logic                 w_load_addr;
    logic                 w_fx_sel;
    logic                 w_fy_sel;
    logic [ADDR_W-1:0]    w_base_sel;
    logic [ADDR_W-1:0]    w_offset;
    logic [c_COL_W-1:0]   w_col;
    logic [c_ROW_W-1:0]   w_row;
    logic                 w_last;
    logic                 w_cap_vld;
    logic [1:0]           w_cap_slot;
    logic                 w_cap_b;
    logic [23:0]          w_rgb;
    logic                 w_keyed;

    assign w_idle   = (r_state == IDLE);
    assign w_start  = w_idle && start;
    assign w_fetch  = (r_state == FETCH);
    assign w_issue  = w_fetch && (r_issue < 2'(BYTES_PER_PIX));

    // While idle the first address is formed straight from the request inputs
    assign w_fx_sel   = w_idle ? flip_x    : r_flip_x;
    assign w_fy_sel   = w_idle ? flip_y    : r_flip_y;
    assign w_base_sel = w_idle ? tile_base : r_base;
    assign w_load_addr = w_start || ((r_state == ADV) && !w_last);

    tile_addr_gen #(
        .TILE_W (TILE_W),
        .TILE_H (TILE_H),
        .ADDR_W (ADDR_W)
    ) u_addr_gen (
        .clk    (clk),
        .resetn (resetn),
        .clear  (w_idle),
        .step   ((r_state == ADV) && !w_last),
        .flip_x (w_fx_sel),
        .flip_y (w_fy_sel),
        .col    (w_col),
        .row    (w_row),
        .last   (w_last),
        .offset (w_offset)
    );

    assign w_cap_vld  = r_tag_vld[ROM_LATENCY-1];
    assign w_cap_slot = r_tag_slot[ROM_LATENCY-1];
    assign w_cap_b    = w_cap_vld && (w_cap_slot == 2'd2);
    assign w_rgb      = {r_red, r_grn, rom_data};
    assign w_keyed    = r_key_en && (w_rgb == KEY_RGB);

    // Request parameters are captured once when a draw is accepted
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_base   <= '0;
            r_x      <= '0;
            r_y      <= '0;
            r_flip_x <= 1'b0;
            r_flip_y <= 1'b0;
            r_key_en <= 1'b0;
        end else if (w_start) begin
            r_base   <= tile_base;
            r_x      <= x_pos;
            r_y      <= y_pos;
            r_flip_x <= flip_x;
            r_flip_y <= flip_y;
            r_key_en <= key_en;
        end
    end

    // State register
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state logic; FETCH ends on the cycle the B byte is captured
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE:    if (start)     w_state_nxt = FETCH;
            FETCH:   if (w_cap_b)   w_state_nxt = w_keyed ? ADV : EMIT;
            EMIT:    if (pix_ready) w_state_nxt = ADV;
            ADV:     w_state_nxt = w_last ? DONE : FETCH;
            DONE:    w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end

    // Byte-issue counter: R, G, B addresses go out on FETCH cycles 0..2
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_issue <= '0;
        end else if (!w_fetch) begin
            r_issue <= '0;
        end else if (w_issue) begin
            r_issue <= r_issue + 2'd1;
        end
    end

    // ROM address: pixel base on entry to FETCH, then +1 for G and B
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            rom_addr <= '0;
        end else if (w_load_addr) begin
            rom_addr <= w_base_sel + w_offset;
        end else if (w_fetch && (r_issue < 2'(BYTES_PER_PIX - 1))) begin
            rom_addr <= rom_addr + ADDR_W'(1);
        end
    end

    // Latency pipe tagging which colour slot each returning byte belongs to
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_tag_vld <= '0;
            for (int i = 0; i < ROM_LATENCY; i++) begin
                r_tag_slot[i] <= '0;
            end
        end else begin
            r_tag_vld[0]  <= w_issue;
            r_tag_slot[0] <= r_issue;
            for (int i = 1; i < ROM_LATENCY; i++) begin
                r_tag_vld[i]  <= r_tag_vld[i-1];
                r_tag_slot[i] <= r_tag_slot[i-1];
            end
        end
    end

    // Hold R and G until B arrives and the pixel can be judged as a whole
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_red <= '0;
            r_grn <= '0;
        end else if (w_cap_vld) begin
            if (w_cap_slot == 2'd0) r_red <= rom_data;
            if (w_cap_slot == 2'd1) r_grn <= rom_data;
        end
    end

    // Pixel output registers, loaded when an opaque pixel enters EMIT and
    // otherwise held, so they stay stable through back-pressure
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            pix_x   <= '0;
            pix_y   <= '0;
            pix_rgb <= '0;
        end else if (w_cap_b && w_fetch && !w_keyed) begin
            pix_x   <= r_x + COORD_W'(w_col);
            pix_y   <= r_y + COORD_W'(w_row);
            pix_rgb <= w_rgb;
        end
    end

    assign pix_valid = (r_state == EMIT);
    assign busy      = !w_idle;
    assign done      = (r_state == DONE);

endmodule : tile_blitter
`default_nettype wire

// File: tb/tb_tile_blitter.sv
`default_nettype none
// ============================================================================
// Module      : tb_tile_blitter
// Description : Directed self-checking bench for tile_blitter (8x8 at
//               latency 1, and 16x4 at latency 3).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_tile_blitter;

    logic        clk = 1'b0;
    logic        resetn;
    logic        start, start2;
    logic [11:0] tile_base;
    logic [7:0]  x_pos, y_pos;
    logic        flip_x, flip_y, key_en, pix_ready;

    logic [11:0] rom_addr, rom_addr2;
    logic [7:0]  rom_data, rom_data2;
    logic        pix_valid, busy, done;
    logic [7:0]  pix_x, pix_y;
    logic [23:0] pix_rgb;
    logic        pix_valid2, busy2, done2;
    logic [7:0]  pix_x2, pix_y2;
    logic [23:0] pix_rgb2;

    always #5 clk = ~clk;

    tile_blitter #(.TILE_W(8), .TILE_H(8), .COORD_W(8), .ADDR_W(12),
                   .ROM_LATENCY(1), .KEY_RGB(24'hFF00FF)) dut (
        .clk(clk), .resetn(resetn), .start(start), .tile_base(tile_base),
        .x_pos(x_pos), .y_pos(y_pos), .flip_x(flip_x), .flip_y(flip_y),
        .key_en(key_en), .rom_addr(rom_addr), .rom_data(rom_data),
        .pix_valid(pix_valid), .pix_ready(pix_ready), .pix_x(pix_x),
        .pix_y(pix_y), .pix_rgb(pix_rgb), .busy(busy), .done(done));

    tile_blitter #(.TILE_W(16), .TILE_H(4), .COORD_W(8), .ADDR_W(12),
                   .ROM_LATENCY(3), .KEY_RGB(24'hFF00FF)) dut2 (
        .clk(clk), .resetn(resetn), .start(start2), .tile_base(tile_base),
        .x_pos(x_pos), .y_pos(y_pos), .flip_x(flip_x), .flip_y(flip_y),
        .key_en(key_en), .rom_addr(rom_addr2), .rom_data(rom_data2),
        .pix_valid(pix_valid2), .pix_ready(pix_ready), .pix_x(pix_x2),
        .pix_y(pix_y2), .pix_rgb(pix_rgb2), .busy(busy2), .done(done2));

    // ROM models: 1-cycle and 3-cycle read pipelines over one shared image
    logic [7:0] mem [4096];
    logic [7:0] r_pipe2 [3];
    always @(posedge clk) rom_data <= mem[rom_addr];
    always @(posedge clk) begin
        r_pipe2[0] <= mem[rom_addr2];
        r_pipe2[1] <= r_pipe2[0];
        r_pipe2[2] <= r_pipe2[1];
    end
    assign rom_data2 = r_pipe2[2];

    int n_chk = 0;
    int n_fail = 0;

    task automatic check_eq(input string tag, input logic [47:0] got, input logic [47:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Transfers captured from the 8x8 instance
    logic [7:0]  gx [64];
    logic [7:0]  gy [64];
    logic [23:0] gc [64];
    int got_n, done_cyc, n_done, last_hs;

    task automatic set_identity();
        for (int a = 0; a < 4096; a++) mem[a] = 8'(a);
    endtask

    task automatic set_keys();
        int keys [5] = '{0, 9, 27, 36, 63};
        for (int i = 0; i < 5; i++) begin
            mem[3*keys[i]]     = 8'hFF;
            mem[3*keys[i] + 1] = 8'h00;
            mem[3*keys[i] + 2] = 8'hFF;
        end
    endtask

    function automatic logic [23:0] ref_px(input logic [11:0] b, input int col, input int row,
                                           input logic fx, input logic fy);
        int sc, sr;
        logic [11:0] a;
        sc = fx ? 7 - col : col;
        sr = fy ? 7 - row : row;
        a  = b + 12'(3 * (sr * 8 + sc));
        return {mem[a], mem[a + 12'd1], mem[a + 12'd2]};
    endfunction

    // Draw one tile on the 8x8 instance; cycle 0 is the first busy cycle.
    // Request inputs are scrambled and a stray start is issued mid-draw.
    task automatic run1(input logic [11:0] b, input logic [7:0] x, input logic [7:0] y,
                        input logic fx, input logic fy, input logic ke,
                        input bit rnd, input int abort_at);
        bit stall, fin;
        logic [40:0] held;
        @(negedge clk);
        tile_base = b; x_pos = x; y_pos = y;
        flip_x = fx; flip_y = fy; key_en = ke;
        start = 1'b1; pix_ready = 1'b1;
        @(negedge clk);
        start = 1'b0;
        got_n = 0; n_done = 0; done_cyc = -1; last_hs = -1;
        stall = 1'b0; fin = 1'b0; held = '0;
        check_eq("busy_rise", busy, 1);
        for (int c = 0; c < 6000 && !fin; c++) begin
            if (abort_at >= 0 && got_n == abort_at) return;
            if (c == 1) begin
                tile_base = ~b; x_pos = 8'h55; y_pos = 8'hAA;
                flip_x = ~fx; flip_y = ~fy; key_en = ~ke;
            end
            start = (c == 50);
            if (stall) check_eq("stall_hold", {pix_valid, pix_x, pix_y, pix_rgb}, held);
            if (done) begin
                n_done++;
                done_cyc = c;
            end
            if (n_done > 0 && !busy) begin
                fin = 1'b1;
            end else begin
                pix_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
                if (pix_valid && pix_ready) begin
                    if (got_n < 64) begin
                        gx[got_n] = pix_x; gy[got_n] = pix_y; gc[got_n] = pix_rgb;
                    end
                    got_n++;
                    last_hs = c;
                    stall = 1'b0;
                end else begin
                    stall = pix_valid;
                    held  = {pix_valid, pix_x, pix_y, pix_rgb};
                end
                @(negedge clk);
            end
        end
        if (!fin) check_eq("timeout", 0, 1);
    endtask

    // Compare captured transfers with the raster/flip/key model
    task automatic check_pixels(input logic [11:0] b, input logic [7:0] x, input logic [7:0] y,
                                input logic fx, input logic fy, input logic ke);
        int j = 0;
        logic [23:0] rgb;
        for (int row = 0; row < 8; row++) begin
            for (int col = 0; col < 8; col++) begin
                rgb = ref_px(b, col, row, fx, fy);
                if (!(ke && rgb == 24'hFF00FF)) begin
                    if (j < got_n && j < 64)
                        check_eq("pixel", {gx[j], gy[j], gc[j]},
                                 {8'(x + col), 8'(y + row), rgb});
                    j++;
                end
            end
        end
        check_eq("pixel_count", got_n, j);
    endtask

    // Draw on the 16x4 latency-3 instance at (30,40), ready held high
    task automatic run2(input logic ke, output int n, output int dc,
                        output logic [40:0] first, output logic [40:0] last);
        @(negedge clk);
        tile_base = '0; x_pos = 8'd30; y_pos = 8'd40;
        flip_x = 1'b0; flip_y = 1'b0; key_en = ke;
        start2 = 1'b1; pix_ready = 1'b1;
        @(negedge clk);
        start2 = 1'b0;
        n = 0; dc = -1; first = '0; last = '0;
        for (int c = 0; c < 3000 && dc < 0; c++) begin
            if (done2) dc = c;
            if (pix_valid2) begin
                if (n == 0) first = {1'b1, pix_x2, pix_y2, pix_rgb2};
                last = {1'b1, pix_x2, pix_y2, pix_rgb2};
                n++;
            end
            @(negedge clk);
        end
        if (dc < 0) check_eq("timeout2", 0, 1);
    endtask

    initial begin
        int n2, dc2, quiet;
        logic [40:0] f2, l2;
        resetn = 1'b0; start = 1'b0; start2 = 1'b0; pix_ready = 1'b0;
        tile_base = '0; x_pos = '0; y_pos = '0;
        flip_x = 1'b0; flip_y = 1'b0; key_en = 1'b0;
        set_identity();
        repeat (3) @(negedge clk);
        check_eq("reset_outs", {pix_valid, busy, done, rom_addr, pix_x, pix_y, pix_rgb}, 0);
        check_eq("reset_outs2", {pix_valid2, busy2, done2}, 0);
        resetn = 1'b1;
        @(negedge clk);

        // Identity tile, no flip
        run1(12'h000, 8'd10, 8'd20, 1'b0, 1'b0, 1'b0, 1'b0, -1);
        check_eq("id_count", got_n, 64);
        check_eq("id_first", {gx[0], gy[0], gc[0]}, {8'd10, 8'd20, 24'h000102});
        check_eq("id_last", {gx[63], gy[63], gc[63]}, {8'd17, 8'd27, 24'hBDBEBF});
        check_eq("id_done_cyc", done_cyc, 384);
        check_eq("id_done_once", n_done, 1);
        check_pixels(12'h000, 8'd10, 8'd20, 1'b0, 1'b0, 1'b0);

        // Both flips
        run1(12'h000, 8'd10, 8'd20, 1'b1, 1'b1, 1'b0, 1'b0, -1);
        check_eq("flip_first", {gx[0], gy[0], gc[0]}, {8'd10, 8'd20, 24'hBDBEBF});
        check_eq("flip_last", {gx[63], gy[63], gc[63]}, {8'd17, 8'd27, 24'h000102});
        check_pixels(12'h000, 8'd10, 8'd20, 1'b1, 1'b1, 1'b0);

        // Colour key: five magenta pixels skipped, 59*6+5*5 cycles
        set_keys();
        run1(12'h000, 8'd10, 8'd20, 1'b0, 1'b0, 1'b1, 1'b0, -1);
        check_eq("key_count", got_n, 59);
        check_eq("key_done_cyc", done_cyc, 379);
        check_eq("key_first", {gx[0], gy[0], gc[0]}, {8'd11, 8'd20, 24'h030405});
        check_pixels(12'h000, 8'd10, 8'd20, 1'b0, 1'b0, 1'b1);
        run1(12'h000, 8'd10, 8'd20, 1'b0, 1'b0, 1'b0, 1'b0, -1);
        check_eq("nokey_count", got_n, 64);
        check_eq("nokey_first", gc[0], 24'hFF00FF);
        check_pixels(12'h000, 8'd10, 8'd20, 1'b0, 1'b0, 1'b0);
        set_identity();

        // Random back-pressure
        run1(12'h123, 8'd3, 8'd4, 1'b1, 1'b0, 1'b0, 1'b1, -1);
        check_pixels(12'h123, 8'd3, 8'd4, 1'b1, 1'b0, 1'b0);
        check_eq("bp_done_once", n_done, 1);
        check_eq("bp_done_after_last", done_cyc, last_hs + 2);

        // Screen and ROM address wrap
        run1(12'hFF0, 8'd252, 8'd250, 1'b0, 1'b0, 1'b0, 1'b0, -1);
        check_eq("wrap_first", {gx[0], gy[0], gc[0]}, {8'd252, 8'd250, 24'hF0F1F2});
        check_eq("wrap_x255", gx[3], 8'd255);
        check_eq("wrap_x0", gx[4], 8'd0);
        check_eq("wrap_addr", {gx[5], gc[5]}, {8'd1, 24'hFF0001});
        check_eq("wrap_addr2", gc[6], 24'h020304);
        check_eq("wrap_y", gy[56], 8'd1);
        check_pixels(12'hFF0, 8'd252, 8'd250, 1'b0, 1'b0, 1'b0);

        // Reset mid-tile after 10 pixels
        run1(12'h000, 8'd10, 8'd20, 1'b0, 1'b0, 1'b0, 1'b0, 10);
        check_eq("pre_reset_busy", busy, 1);
        resetn = 1'b0;
        #1;
        check_eq("midreset_outs", {pix_valid, busy, done, rom_addr, pix_x, pix_y, pix_rgb}, 0);
        @(negedge clk);
        resetn = 1'b1;
        quiet = 0;
        repeat (20) begin
            @(negedge clk);
            if (done || busy) quiet++;
        end
        check_eq("no_done_after_reset", quiet, 0);
        run1(12'h000, 8'd10, 8'd20, 1'b0, 1'b0, 1'b0, 1'b0, -1);
        check_eq("redraw_done_cyc", done_cyc, 384);
        check_pixels(12'h000, 8'd10, 8'd20, 1'b0, 1'b0, 1'b0);

        // 16x4 at latency 3: 8 cycles per opaque pixel, 7 per skipped
        run2(1'b0, n2, dc2, f2, l2);
        check_eq("l3_count", n2, 64);
        check_eq("l3_done_cyc", dc2, 512);
        check_eq("l3_first", f2, {1'b1, 8'd30, 8'd40, 24'h000102});
        check_eq("l3_last", l2, {1'b1, 8'd45, 8'd43, 24'hBDBEBF});
        set_keys();
        run2(1'b1, n2, dc2, f2, l2);
        check_eq("l3_key_count", n2, 59);
        check_eq("l3_key_done_cyc", dc2, 507);
        check_eq("l3_key_first", f2, {1'b1, 8'd31, 8'd40, 24'h030405});
        check_eq("l3_key_last", l2, {1'b1, 8'd44, 8'd43, 24'hBABBBC});

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule : tb_tile_blitter
`default_nettype wire
